// File: rtl/xor_host_link.sv
// Host-side link for the XOR encryption core: serializes key and message onto the
// core's shared serial input, then deserializes the returned ciphertext stream.
module xor_host_link #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                iStart,
  input  logic [KEY_SIZE-1:0] iKey,
  input  logic [MSG_SIZE-1:0] iMessage,
  output logic                oBusy,
  output logic                oData,
  output logic                oKey_flag,
  output logic                oMsg_flag,
  input  logic                iCt_data,
  input  logic                iCt_flag,
  output logic [MSG_SIZE-1:0] oCiphertext,
  output logic                oDone,
  output logic                oError
);

  localparam int CNT_W = $clog2(MSG_SIZE) + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_KEY, S_GAP, S_LOAD_MSG, S_WAIT_CT, S_CAPTURE, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [KEY_SIZE-1:0] key_sr_q, key_sr_d;
  logic [MSG_SIZE-1:0] msg_sr_q, msg_sr_d;
  logic [MSG_SIZE-1:0] cap_q, cap_d;
  logic [MSG_SIZE-1:0] ct_q, ct_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                busy_q, busy_d;
  logic                data_q, data_d;
  logic                key_flag_q, key_flag_d;
  logic                msg_flag_q, msg_flag_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic [CNT_W-1:0]    bit_cnt_inc;
  logic [MSG_SIZE-1:0] cap_shift;

  assign bit_cnt_inc = bit_cnt_q + 1'b1;
  assign cap_shift   = {cap_q[MSG_SIZE-2:0], iCt_data};

  // Serial outputs are registered, so each state's flag/data is computed on the
  // edge that enters (or continues) that state.
  always_comb begin
    state_d    = state_q;
    key_sr_d   = key_sr_q;
    msg_sr_d   = msg_sr_q;
    cap_d      = cap_q;
    ct_d       = ct_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    busy_d     = (state_q != S_IDLE);
    data_d     = 1'b0;
    key_flag_d = 1'b0;
    msg_flag_d = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          // busy_q still high during an error pulse: start waits one more cycle
          if (iStart && !busy_q) begin
            state_d    = S_LOAD_KEY;
            key_sr_d   = iKey << 1;
            msg_sr_d   = iMessage;
            data_d     = iKey[KEY_SIZE-1];
            key_flag_d = 1'b1;
            bit_cnt_d  = CNT_W'(1);
          end
        end
        S_LOAD_KEY: begin
          if (bit_cnt_q == CNT_W'(KEY_SIZE)) begin
            state_d   = S_GAP;
            bit_cnt_d = '0;
          end else begin
            data_d     = key_sr_q[KEY_SIZE-1];
            key_sr_d   = key_sr_q << 1;
            key_flag_d = 1'b1;
            bit_cnt_d  = bit_cnt_inc;
          end
        end
        S_GAP: begin
          state_d    = S_LOAD_MSG;
          data_d     = msg_sr_q[MSG_SIZE-1];
          msg_sr_d   = msg_sr_q << 1;
          msg_flag_d = 1'b1;
          bit_cnt_d  = CNT_W'(1);
        end
        S_LOAD_MSG: begin
          if (bit_cnt_q == CNT_W'(MSG_SIZE)) begin
            state_d   = S_WAIT_CT;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
          end else begin
            data_d     = msg_sr_q[MSG_SIZE-1];
            msg_sr_d   = msg_sr_q << 1;
            msg_flag_d = 1'b1;
            bit_cnt_d  = bit_cnt_inc;
          end
        end
        S_WAIT_CT, S_CAPTURE: begin
          if (iCt_flag) begin
            cap_d     = cap_shift;
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == CNT_W'(MSG_SIZE)) begin
              // ciphertext and done are registered on FINISH entry so they
              // appear the cycle after the last sample
              state_d = S_FINISH;
              ct_d    = cap_shift;
              done_d  = 1'b1;
            end else begin
              state_d = S_CAPTURE;
            end
          end else if (state_q == S_CAPTURE || to_cnt_q == TO_W'(TIMEOUT)) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            error_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        S_FINISH: begin
          state_d   = S_IDLE;
          bit_cnt_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE) || error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      key_sr_q   <= '0;
      msg_sr_q   <= '0;
      cap_q      <= '0;
      ct_q       <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      data_q     <= 1'b0;
      key_flag_q <= 1'b0;
      msg_flag_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_sr_q   <= key_sr_d;
      msg_sr_q   <= msg_sr_d;
      cap_q      <= cap_d;
      ct_q       <= ct_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      key_flag_q <= key_flag_d;
      msg_flag_q <= msg_flag_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign oBusy       = busy_q;
  assign oData       = data_q;
  assign oKey_flag   = key_flag_q;
  assign oMsg_flag   = msg_flag_q;
  assign oCiphertext = ct_q;
  assign oDone       = done_q;
  assign oError      = error_q;

endmodule

// File: tb/tb_xor_host_link.sv
// Directed bench for xor_host_link with a loopback model of the XOR core.
module tb_xor_host_link;
  localparam logic [63:0] M1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT1 = 64'hAD8FE9CB25076143;
  localparam logic [63:0] M2  = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] CT2 = 64'hA5A55A5AA5A55A5A;

  logic        clk = 1'b0;
  logic        rst, ena, iStart, iCt_data, iCt_flag;
  logic [7:0]  iKey;
  logic [63:0] iMessage, oCiphertext;
  logic        oBusy, oData, oKey_flag, oMsg_flag, oDone, oError;

  int n_chk = 0;
  int n_fail = 0;

  xor_host_link #(.MSG_SIZE(64), .KEY_SIZE(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .ena(ena), .iStart(iStart), .iKey(iKey), .iMessage(iMessage),
    .oBusy(oBusy), .oData(oData), .oKey_flag(oKey_flag), .oMsg_flag(oMsg_flag),
    .iCt_data(iCt_data), .iCt_flag(iCt_flag), .oCiphertext(oCiphertext),
    .oDone(oDone), .oError(oError)
  );

  always #5 clk = ~clk;

  // Loopback core: collects key/message bits, returns msg ^ {8{key}} after 3 cycles.
  int          m_limit = 64;
  int          m_mc, m_wait, m_idx;
  logic [7:0]  m_key;
  logic [63:0] m_msg, m_ct;
  always @(negedge clk) begin
    if (rst) begin
      m_mc = 0; m_wait = -1; m_idx = 0; iCt_flag = 1'b0; iCt_data = 1'b0;
      m_key = '0; m_msg = '0; m_ct = '0;
    end else begin
      iCt_flag = 1'b0; iCt_data = 1'b0;
      if (m_wait == 0) begin
        if (m_idx < m_limit) begin
          iCt_flag = 1'b1; iCt_data = m_ct[63-m_idx]; m_idx++;
        end else m_wait = -1;
      end else if (m_wait > 0) m_wait--;
      if (oKey_flag) m_key = {m_key[6:0], oData};
      if (oMsg_flag) begin
        m_msg = {m_msg[62:0], oData}; m_mc++;
        if (m_mc == 64) begin
          m_ct = m_msg ^ {8{m_key}}; m_mc = 0; m_idx = 0; m_wait = 3;
        end
      end
    end
  end

  // Observes one transaction; cycle 1 is the first cycle after start acceptance.
  task automatic watch(input int maxc, input bit hold, input int stall_at,
                       output int kf, output int mf, output logic [7:0] ks,
                       output int first_k, output int first_m, output int done_c,
                       output int err_c, output int stall_hi, output logic busy_p,
                       output logic busy_after);
    kf = 0; mf = 0; ks = '0; first_k = -1; first_m = -1; done_c = -1; err_c = -1;
    stall_hi = 0; busy_p = 1'b0; busy_after = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (!hold) iStart = 1'b0;
      if (done_c >= 0 || err_c >= 0) begin busy_after = oBusy; break; end
      if (oKey_flag) begin kf++; ks = {ks[6:0], oData}; if (first_k < 0) first_k = c; end
      if (oMsg_flag) begin mf++; if (first_m < 0) first_m = c; end
      if (stall_at > 0 && c > stall_at && c <= stall_at + 5 &&
          (oKey_flag || oMsg_flag || oData)) stall_hi++;
      if (stall_at > 0 && c == stall_at) ena = 1'b0;
      if (stall_at > 0 && c == stall_at + 5) ena = 1'b1;
      if (oDone) begin done_c = c; busy_p = oBusy; end
      if (oError) begin err_c = c; busy_p = oBusy; end
    end
  endtask

  int kf, mf, fk, fm, dc, ec, sh;
  logic [7:0] ks;
  logic bp, ba;

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; iStart = 1'b0; iKey = '0; iMessage = '0;
    repeat (3) @(negedge clk);
    n_chk++; if ({oBusy, oData, oKey_flag, oMsg_flag, oDone, oError} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 000000",
                         {oBusy, oData, oKey_flag, oMsg_flag, oDone, oError}); end
    n_chk++; if (oCiphertext !== 64'h0) begin
      n_fail++; $display("FAIL reset_ct: got %h want 0", oCiphertext); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    m_limit = 64; iKey = 8'hAC; iMessage = M1; iStart = 1'b1;
    watch(200, 1'b0, 0, kf, mf, ks, fk, fm, dc, ec, sh, bp, ba);
    n_chk++; if (kf !== 8) begin n_fail++; $display("FAIL basic_key_cycles: got %0d want 8", kf); end
    n_chk++; if (ks !== 8'hAC) begin n_fail++; $display("FAIL basic_key_stream: got %b want 10101100", ks); end
    n_chk++; if (fk !== 1) begin n_fail++; $display("FAIL basic_first_key: got %0d want 1", fk); end
    n_chk++; if (fm !== 10) begin n_fail++; $display("FAIL basic_first_msg: got %0d want 10", fm); end
    n_chk++; if (mf !== 64) begin n_fail++; $display("FAIL basic_msg_cycles: got %0d want 64", mf); end
    n_chk++; if (dc !== 141) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 141", dc); end
    n_chk++; if (ec !== -1) begin n_fail++; $display("FAIL basic_no_error: got %0d want -1", ec); end
    n_chk++; if (oCiphertext !== CT1) begin n_fail++; $display("FAIL basic_ct: got %h want %h", oCiphertext, CT1); end
    n_chk++; if (bp !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 1", bp); end
    n_chk++; if (ba !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b want 0", ba); end
  endtask

  task automatic test_timeout();
    m_limit = 0; iKey = 8'h5A; iMessage = M2; iStart = 1'b1;
    watch(400, 1'b0, 0, kf, mf, ks, fk, fm, dc, ec, sh, bp, ba);
    n_chk++; if (ec !== 330) begin n_fail++; $display("FAIL timeout_error_cycle: got %0d want 330", ec); end
    n_chk++; if (dc !== -1) begin n_fail++; $display("FAIL timeout_no_done: got %0d want -1", dc); end
    n_chk++; if (oCiphertext !== CT1) begin n_fail++; $display("FAIL timeout_ct_held: got %h want %h", oCiphertext, CT1); end
    n_chk++; if (bp !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_at_err: got %b want 1", bp); end
    n_chk++; if (ba !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_drop: got %b want 0", ba); end
  endtask

  task automatic test_truncate();
    m_limit = 40; iKey = 8'h5A; iMessage = M2; iStart = 1'b1;
    watch(200, 1'b0, 0, kf, mf, ks, fk, fm, dc, ec, sh, bp, ba);
    n_chk++; if (ec !== 118) begin n_fail++; $display("FAIL trunc_error_cycle: got %0d want 118", ec); end
    n_chk++; if (dc !== -1) begin n_fail++; $display("FAIL trunc_no_done: got %0d want -1", dc); end
    n_chk++; if (oCiphertext !== CT1) begin n_fail++; $display("FAIL trunc_ct_held: got %h want %h", oCiphertext, CT1); end
    m_limit = 64; iStart = 1'b1;
    watch(200, 1'b0, 0, kf, mf, ks, fk, fm, dc, ec, sh, bp, ba);
    n_chk++; if (dc !== 141) begin n_fail++; $display("FAIL retry_done_cycle: got %0d want 141", dc); end
    n_chk++; if (oCiphertext !== CT2) begin n_fail++; $display("FAIL retry_ct: got %h want %h", oCiphertext, CT2); end
  endtask

  task automatic test_stall();
    m_limit = 64; iKey = 8'hAC; iMessage = M1; iStart = 1'b1;
    watch(200, 1'b0, 30, kf, mf, ks, fk, fm, dc, ec, sh, bp, ba);
    n_chk++; if (sh !== 0) begin n_fail++; $display("FAIL stall_outputs_low: got %0d high cycles want 0", sh); end
    n_chk++; if (mf !== 64) begin n_fail++; $display("FAIL stall_msg_cycles: got %0d want 64", mf); end
    n_chk++; if (dc !== 146) begin n_fail++; $display("FAIL stall_done_cycle: got %0d want 146", dc); end
    n_chk++; if (oCiphertext !== CT1) begin n_fail++; $display("FAIL stall_ct: got %h want %h", oCiphertext, CT1); end
  endtask

  task automatic test_start_held_and_reset();
    m_limit = 64; iKey = 8'h5A; iMessage = M2; iStart = 1'b1;
    watch(200, 1'b1, 0, kf, mf, ks, fk, fm, dc, ec, sh, bp, ba);
    n_chk++; if (kf !== 8) begin n_fail++; $display("FAIL held_single_txn: got %0d key cycles want 8", kf); end
    n_chk++; if (dc !== 141) begin n_fail++; $display("FAIL held_done_cycle: got %0d want 141", dc); end
    n_chk++; if (ba !== 1'b0) begin n_fail++; $display("FAIL held_idle_gap: got busy %b want 0", ba); end
    @(negedge clk);
    n_chk++; if ({oBusy, oKey_flag} !== 2'b11) begin
      n_fail++; $display("FAIL held_restart: got busy,key %b want 11", {oBusy, oKey_flag}); end
    repeat (88) @(negedge clk);
    n_chk++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL held_in_capture: got busy %b want 1", oBusy); end
    rst = 1'b1; iStart = 1'b0;
    @(negedge clk);
    n_chk++; if ({oBusy, oData, oKey_flag, oMsg_flag, oDone, oError} !== 6'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b want 000000",
                         {oBusy, oData, oKey_flag, oMsg_flag, oDone, oError}); end
    n_chk++; if (oCiphertext !== 64'h0) begin
      n_fail++; $display("FAIL midreset_ct: got %h want 0", oCiphertext); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; iStart = 1'b0; iKey = '0; iMessage = '0;
    test_reset();
    test_basic();
    test_timeout();
    test_truncate();
    test_stall();
    test_start_held_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xor_host_link.md
# xor_host_link

Host-side link controller for the XOR encryption core. It accepts a parallel key and message through a start/busy handshake and serializes them MSB-first onto the core's shared serial data input, using the separate key-load and message-load flags. It then deserializes the ciphertext stream the core emits on its serial data/flag outputs and returns the parallel ciphertext with a done or error pulse. It sits directly upstream of the core inputs (data bit, key flag, message flag) and directly downstream of its ciphertext outputs (data bit, data flag).

## Interface
- MSG_SIZE, 64: message and ciphertext width in bits
- KEY_SIZE, 8: key width in bits
- TIMEOUT, 255: max cycles to wait for the first ciphertext flag after the message is loaded

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ena  in  1  enable; low freezes all state
- iStart  in  1  start request; accepted only in IDLE with ena=1
- iKey  in  KEY_SIZE  key; latched on start acceptance
- iMessage  in  MSG_SIZE  plaintext; latched on start acceptance
- oBusy  out  1  high in every state except IDLE
- oData  out  1  serial bit to the core data input
- oKey_flag  out  1  key-load flag to the core
- oMsg_flag  out  1  message-load flag to the core
- iCt_data  in  1  serial ciphertext bit from the core
- iCt_flag  in  1  ciphertext-valid flag from the core
- oCiphertext  out  MSG_SIZE  captured ciphertext; holds its value until the next successful capture
- oDone  out  1  one-cycle pulse: capture complete, oCiphertext valid
- oError  out  1  one-cycle pulse: timeout or truncated ciphertext

## Operation
- States: IDLE, LOAD_KEY, GAP, LOAD_MSG, WAIT_CT, CAPTURE, FINISH.
- IDLE: if iStart=1, latch iKey and iMessage into shift registers, then go to LOAD_KEY. iCt_flag is ignored in IDLE.
- LOAD_KEY: oKey_flag=1; oData = key shift-register MSB; shift left each cycle. After KEY_SIZE cycles, go to GAP.
- GAP: one cycle with both flags low and oData=0. Then go to LOAD_MSG.
- LOAD_MSG: oMsg_flag=1; same MSB-first shifting for MSG_SIZE cycles. Then go to WAIT_CT and clear the timeout counter.
- WAIT_CT: on iCt_flag=1, sample iCt_data as bit 1 and go to CAPTURE. If the counter reaches TIMEOUT with no flag, pulse oError and go to IDLE.
- CAPTURE: while iCt_flag=1, shift iCt_data into the LSB of the capture register, MSB-first overall.
  - After the MSG_SIZE-th sample, go to FINISH.
  - If iCt_flag=0 before MSG_SIZE samples, pulse oError, go to IDLE, and leave oCiphertext unchanged.
- FINISH: load the capture register into oCiphertext, pulse oDone, go to IDLE.
- Any iCt_flag bits after the MSG_SIZE-th sample are ignored.
- iStart while oBusy=1 is ignored. There is no queueing.
- Counters:
  - Bit counter: clog2(MSG_SIZE)+1 bits, shared by the load and capture phases.
  - Timeout counter: clog2(TIMEOUT+1) bits, saturating.
- ena=0: state, counters and shift registers hold; oKey_flag, oMsg_flag and oData are forced to 0; oDone and oError are not asserted. On resume, operation continues from the held state.

## Timing
- Reset: IDLE; all outputs 0, including oCiphertext; all counters 0. A reset mid-transfer aborts at once with no oDone or oError.
- Outputs are registered.
- Start accepted at cycle 0:
  - oKey_flag high in cycles 1..KEY_SIZE.
  - GAP at cycle KEY_SIZE+1.
  - oMsg_flag high in cycles KEY_SIZE+2 .. KEY_SIZE+MSG_SIZE+1.
  - WAIT_CT from cycle KEY_SIZE+MSG_SIZE+2.
- oBusy rises in cycle 1 and falls in the cycle after oDone or oError.
- oDone is asserted one cycle after the cycle in which the MSG_SIZE-th ciphertext bit is sampled.
- Timeout: oError is asserted TIMEOUT+1 cycles after entering WAIT_CT when iCt_flag stays low.
- iCt_flag=1 in the same cycle the counter reaches TIMEOUT: the flag wins and the bit is captured.

## Test plan
- Key 0xAC, message 0x0123456789ABCDEF, loopback model returning msg ^ {8{key}} 3 cycles after the load ends:
  - oKey_flag high for exactly 8 cycles, oData stream 1,0,1,0,1,1,0,0.
  - oMsg_flag high for 64 cycles.
  - oDone with oCiphertext = 0xAD8FE9CB2507614 3; precisely 0xAD8FE9CB250761 43 read as 0xAD8FE9CB25076143.
- Model never raises iCt_flag: oError pulses exactly 256 cycles after WAIT_CT entry; oCiphertext retains the prior value; oBusy drops the next cycle.
- Model drops iCt_flag after 40 bits: oError pulse, no oDone, oCiphertext unchanged; a second start then completes normally.
- ena low for 5 cycles in the middle of LOAD_MSG: flags low during the stall; total oMsg_flag-high cycles still 64; the ciphertext matches the no-stall run.
- iStart held high continuously: exactly one transaction per IDLE visit; rst pulsed during CAPTURE returns all outputs to 0 on the next edge.
